// File: rtl/condicionador_pkg.sv
// Shared definitions for the input-conditioning stage ahead of jogo_desafio_memoria.
package condicionador_pkg;

    localparam int unsigned NUM_BOTOES = 4;
    localparam int unsigned ESTADO_W   = 4;

    localparam logic [ESTADO_W-1:0] COD_LIVRE     = 4'd0;
    localparam logic [ESTADO_W-1:0] COD_ATIVO     = 4'd1;
    localparam logic [ESTADO_W-1:0] COD_BLOQUEADO = 4'd2;

    typedef enum logic [ESTADO_W-1:0] {
        LIVRE     = COD_LIVRE,
        ATIVO     = COD_ATIVO,
        BLOQUEADO = COD_BLOQUEADO
    } estado_t;

    function automatic logic eh_one_hot(input logic [NUM_BOTOES-1:0] v);
        return (v != '0) && ((v & (v - NUM_BOTOES'(1))) == '0);
    endfunction

endpackage

// File: rtl/condicionador_entradas_debounce_bit.sv
// Single-bit debouncer: the stable level flips only after DEBOUNCE_CICLOS
// consecutive samples that disagree with it.
module debounce_bit #(
    parameter int unsigned DEBOUNCE_CICLOS = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic entrada,
    output logic estavel
);

    localparam int unsigned CONT_W = $clog2(DEBOUNCE_CICLOS);
    localparam logic [CONT_W-1:0] CONT_MAX = CONT_W'(DEBOUNCE_CICLOS - 1);

    logic [CONT_W-1:0] cont;

    // cont never passes CONT_MAX: reaching it either flips the level or is cleared
    always_ff @(posedge clock) begin
        if (reset) begin
            estavel <= 1'b0;
            cont    <= '0;
        end else if (entrada == estavel) begin
            cont <= '0;
        end else if (cont == CONT_MAX) begin
            estavel <= ~estavel;
            cont    <= '0;
        end else begin
            cont <= cont + CONT_W'(1);
        end
    end

endmodule

// File: rtl/condicionador_entradas.sv
// Debounce, one-button-at-a-time filter and start pulse for the memory game.
// Optional macro CONDIC_SINCRONIZADOR_EN adds 2-flop synchronizers on the raw inputs.
module condicionador_entradas
    import condicionador_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CICLOS = 50000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_BOTOES-1:0] botoes_brutos,
    input  logic                  jogar_bruto,
    output logic [NUM_BOTOES-1:0] botoes,
    output logic                  jogar,
    output logic [NUM_BOTOES:0]   db_estavel,
    output logic [ESTADO_W-1:0]   db_estado
);

    localparam int unsigned NUM_ENTRADAS = NUM_BOTOES + 1;

    logic [NUM_ENTRADAS-1:0] brutos;
    logic [NUM_ENTRADAS-1:0] entradas;
    logic [NUM_ENTRADAS-1:0] estavel;
    logic [NUM_BOTOES-1:0]   d;
    logic [NUM_BOTOES-1:0]   botoes_prox;
    logic                    jogar_ant;
    estado_t                 estado, estado_prox;

    assign brutos = {jogar_bruto, botoes_brutos};

`ifdef CONDIC_SINCRONIZADOR_EN
    logic [NUM_ENTRADAS-1:0] sinc_1, sinc_2;

    always_ff @(posedge clock) begin
        if (reset) begin
            sinc_1 <= '0;
            sinc_2 <= '0;
        end else begin
            sinc_1 <= brutos;
            sinc_2 <= sinc_1;
        end
    end

    assign entradas = sinc_2;
`else
    assign entradas = brutos;
`endif

    for (genvar i = 0; i < NUM_ENTRADAS; i++) begin : g_db
        debounce_bit #(
            .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
        ) u_db (
            .clock  (clock),
            .reset  (reset),
            .entrada(entradas[i]),
            .estavel(estavel[i])
        );
    end

    assign d          = estavel[NUM_BOTOES-1:0];
    assign db_estavel = estavel;
    assign db_estado  = estado;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado    <= LIVRE;
            botoes    <= '0;
            jogar_ant <= 1'b0;
            jogar     <= 1'b0;
        end else begin
            estado    <= estado_prox;
            botoes    <= botoes_prox;
            jogar_ant <= estavel[NUM_BOTOES];
            jogar     <= estavel[NUM_BOTOES] & ~jogar_ant;
        end
    end

    // In ATIVO the captured code is held; extra buttons are ignored until all release
    always_comb begin
        estado_prox = estado;
        botoes_prox = botoes;
        case (estado)
            LIVRE: begin
                botoes_prox = '0;
                if (eh_one_hot(d)) begin
                    estado_prox = ATIVO;
                    botoes_prox = d;
                end else if (d != '0) begin
                    estado_prox = BLOQUEADO;
                end
            end
            ATIVO: begin
                if (d == '0) begin
                    estado_prox = LIVRE;
                    botoes_prox = '0;
                end
            end
            BLOQUEADO: begin
                botoes_prox = '0;
                if (d == '0) begin
                    estado_prox = LIVRE;
                end
            end
            default: begin
                estado_prox = LIVRE;
                botoes_prox = '0;
            end
        endcase
    end

endmodule

// File: doc/condicionador_entradas.md
Name: condicionador_entradas

Overview:
Input-conditioning stage placed directly upstream of jogo_desafio_memoria, between the raw board push-buttons and the game's `botoes`/`jogar` inputs.
- Debounces 4 colour buttons plus the start button.
- Enforces one-button-at-a-time: `botoes` is either all-zero or exactly one-hot, held while pressed.
- Converts `jogar` into a clean single-cycle pulse.
- Exposes FSM state for a hexa7seg debug display.

Parameters:
- DEBOUNCE_CICLOS, 50000: consecutive equal samples needed to accept a new level (1 ms at 50 MHz); legal range 2..2^20.
- CONT_W, $clog2(DEBOUNCE_CICLOS): width of each debounce counter; derived, never overridden.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; only reset source.
- botoes_brutos  in  4  raw asynchronous button levels, 1 = pressed.
- jogar_bruto  in  1  raw asynchronous start button, 1 = pressed.
- botoes  out  4  conditioned buttons to the game: 0000 or exactly one-hot, registered.
- jogar  out  1  one-cycle pulse per accepted start press, registered.
- db_estavel  out  5  debounced levels {jogar, botoes[3:0]}.
- db_estado  out  4  FSM code: LIVRE=0, ATIVO=1, BLOQUEADO=2.

Behaviour:
- Clock and reset: single clock `clock`; reset is synchronous and active-high (already decided).
- Reset values: botoes=0, jogar=0, db_estavel=0, all counters=0, state=LIVRE.
- Reset mid-operation: everything returns to the reset values on that edge. A button still held after reset is treated as a new press and is accepted after DEBOUNCE_CICLOS cycles.
- Debounce, per bit, 5 independent instances:
  - Stable level starts at 0.
  - Each edge where the sample differs from the stable level, the counter increments.
  - Any edge where the sample equals the stable level clears the counter.
  - At the edge where the DEBOUNCE_CICLOS-th consecutive differing sample occurs, the stable level flips and the counter clears.
  - Glitches shorter than DEBOUNCE_CICLOS cycles never change the stable level.
  - The counter saturates and never wraps.
- Button FSM, evaluated on the debounced vector d[3:0]:
  - LIVRE:
    - d==0: stay, botoes=0.
    - d one-hot: go to ATIVO; botoes<=d on the same edge.
    - d has ≥2 bits set: go to BLOQUEADO, botoes stays 0.
  - ATIVO:
    - botoes holds the captured code.
    - Extra buttons added while in ATIVO are ignored.
    - d==0: go to LIVRE and botoes<=0 on the same edge.
  - BLOQUEADO: botoes=0 until d==0, then go to LIVRE.
  - Simultaneous debounce of two bits on the same edge counts as ≥2 bits, i.e. BLOQUEADO.
- Start pulse: jogar<=1 for exactly one cycle on the edge after the debounced jogar rises. It is independent of the button FSM and has no auto-repeat while held.
- Latency:
  - Raw press to debounced level: DEBOUNCE_CICLOS edges.
  - Debounced level to botoes/jogar: +1 edge.
  - Release has the same latency as press.

Optional Feature:
Macro CONDIC_SINCRONIZADOR_EN.
- Defined: each raw input passes through a 2-flop synchronizer (reset to 0) before debounce. Total press latency becomes DEBOUNCE_CICLOS+3 edges.
- Undefined: raw inputs feed the debouncers directly, latency DEBOUNCE_CICLOS+1. Intended only for simulation or already-synchronous sources.

Decomposition:
- Shared package (condicionador_pkg):
  - state encodings LIVRE/ATIVO/BLOQUEADO as 4-bit localparams, matching the db_estado codes;
  - NUM_BOTOES=4.
- Sub-module debounce_bit:
  - ports: clock, reset, entrada, estavel;
  - parameter DEBOUNCE_CICLOS;
  - instantiated 5 times.
- The top-level module holds the synchronizers, FSM, and jogar edge detector.

Test Plan (DEBOUNCE_CICLOS=4, macro undefined):
- Reset check: assert reset 2 cycles with all inputs 0 → botoes=0000, jogar=0, db_estado=0.
- Normal press: botoes_brutos=0100 held 10 cycles from edge 1 → db_estavel[2]=1 after edge 4, botoes=0100 after edge 5, db_estado=1. Release → botoes=0000 exactly 5 edges after release.
- Bounce rejection: botoes_brutos toggles 0001/0000 every 2 cycles for 20 cycles → botoes stays 0000, counter never reaches 4.
- Two-button lockout: 0011 applied on the same edge → db_estado=2, botoes=0000. Release to 0000 → returns to LIVRE.
- Second button while held: press 1000, then add 0010 → botoes stays 1000 until all released.
- Start pulse and reset: jogar_bruto held 20 cycles → exactly one jogar pulse, 5 edges after the press. Reset while 0001 is held → botoes=0 immediately, then botoes=0001 again 5 edges after reset deasserts.
